// File: rtl/tq_pkg.sv
// tq_pkg: shared size/state encodings and helpers for the TQ pipeline.
package tq_pkg;
  typedef enum logic [1:0] {TQ_SIZE_4, TQ_SIZE_8, TQ_SIZE_16, TQ_SIZE_32} tq_size_e;
  typedef enum logic [1:0] {ST_IDLE, ST_PASS0, ST_PASS1, ST_DRAIN} tq_state_e;
  function automatic logic [5:0] rows_of_size(input logic [1:0] size);
    return 6'd4 << size;
  endfunction
endpackage

// File: rtl/tq_align_dly.sv
// tq_align_dly: stall-able DEPTH-stage shift register with async active-low clear.
module tq_align_dly #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [DEPTH*W-1:0] sr_q, sr_d;
  always_comb begin
    sr_d = en ? (DEPTH*W)'({sr_q, d}) : sr_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end
  assign q = sr_q[DEPTH*W-1 -: W];
endmodule

// File: rtl/tq_premuat_sched.sv
// tq_premuat_sched: sequences row/column passes for the premuat stages and
// issues permutation enables aligned to the datapath register stages.
module tq_premuat_sched
  import tq_pkg::*;
#(
  parameter int PIPE_DEPTH = 2,
  parameter int ROW_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_size,
  input  logic             i_inverse,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_issue_valid,
  output logic [ROW_W-1:0] o_row,
  output logic             o_pass,
  output logic             o_dly_valid,
  output logic             o_en_8,
  output logic             o_en_16,
  output logic             o_en_32,
  output logic             o_inverse,
  output logic             o_done
);
  tq_state_e        state_q, state_d;
  tq_size_e         size_q, size_d;
  logic [ROW_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dcnt_q, dcnt_d;
  logic             inv_q, inv_d, done_q, done_d;
  logic             last_row;
  logic [4:0]       dly_in, dly_out;

  assign last_row = cnt_q == ROW_W'(rows_of_size(size_q) - 6'd1);

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    inv_d   = inv_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (i_start) begin
        state_d = ST_PASS0;
        size_d  = tq_size_e'(i_size);
        inv_d   = i_inverse;
        cnt_d   = '0;
      end
      ST_PASS0, ST_PASS1: if (i_ready) begin
        cnt_d = last_row ? '0 : cnt_q + 1'b1;
        if (last_row) begin
          state_d = (state_q == ST_PASS0) ? ST_PASS1 : ST_DRAIN;
          dcnt_d  = '0;
        end
      end
      ST_DRAIN: if (i_ready) begin
        // Leaving here lands in IDLE with done raised, so busy is already low.
        if (dcnt_q == 3'(PIPE_DEPTH - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      size_q  <= TQ_SIZE_4;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
    end
  end

  assign o_busy        = state_q != ST_IDLE;
  assign o_issue_valid = state_q == ST_PASS0 || state_q == ST_PASS1;
  assign o_row         = cnt_q;
  assign o_pass        = state_q == ST_PASS1;
  assign o_done        = done_q;

  assign dly_in = {o_issue_valid,
                   o_issue_valid & (size_q != TQ_SIZE_4),
                   o_issue_valid & (size_q == TQ_SIZE_16 || size_q == TQ_SIZE_32),
                   o_issue_valid & (size_q == TQ_SIZE_32),
                   o_issue_valid & inv_q};

  tq_align_dly #(.W(5), .DEPTH(PIPE_DEPTH)) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (i_ready),
    .d     (dly_in),
    .q     (dly_out)
  );

  assign {o_dly_valid, o_en_8, o_en_16, o_en_32, o_inverse} = dly_out;
endmodule

// File: tb/tb_tq_premuat_sched.sv
// tb_tq_premuat_sched: scoreboard bench for the premuat row/column sequencer.
module tb_tq_premuat_sched;
  localparam int P     = 2;
  localparam int ROW_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start, i_inverse, i_ready;
  logic [1:0]       i_size;
  logic             o_busy, o_issue_valid, o_pass, o_dly_valid;
  logic             o_en_8, o_en_16, o_en_32, o_inverse, o_done;
  logic [ROW_W-1:0] o_row;
  int               n_tests = 0;
  int               n_fail  = 0;

  tq_premuat_sched #(.PIPE_DEPTH(P), .ROW_W(ROW_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_size        (i_size),
    .i_inverse     (i_inverse),
    .i_ready       (i_ready),
    .o_busy        (o_busy),
    .o_issue_valid (o_issue_valid),
    .o_row         (o_row),
    .o_pass        (o_pass),
    .o_dly_valid   (o_dly_valid),
    .o_en_8        (o_en_8),
    .o_en_16       (o_en_16),
    .o_en_32       (o_en_32),
    .o_inverse     (o_inverse),
    .o_done        (o_done)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] all_outs();
    return {o_busy, o_issue_valid, o_row, o_pass, o_dly_valid,
            o_en_8, o_en_16, o_en_32, o_inverse, o_done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_block(input logic [1:0] sz, input logic inv, input int stall_row,
                           input bit mid_start);
    logic [5:0]  iss_q[$];
    logic [3:0]  dly_q[$];
    int          cyc_q[$];
    int          n, exp_done, cyc, stall_left, ic;
    bit          done_seen, stalled, prev_ready;
    logic [14:0] cur, snap;
    n          = 4 << sz;
    exp_done   = 2 * n + P + 1 + (stall_row >= 0 ? 3 : 0);
    done_seen  = 0;
    stalled    = 0;
    stall_left = 0;
    prev_ready = 1;
    snap       = '0;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < n; r++) begin
        iss_q.push_back({p[0], r[4:0]});
        dly_q.push_back({sz != 2'd0, sz >= 2'd2, sz == 2'd3, inv});
      end
    @(negedge clk);
    i_size = sz; i_inverse = inv; i_start = 1'b1; i_ready = 1'b1;
    @(posedge clk);
    cyc = 0;
    #1 i_start = 1'b0; i_size = ~sz; i_inverse = ~inv;
    while (!done_seen && cyc < exp_done + 20) begin
      @(negedge clk);
      cyc++;
      cur = all_outs();
      if (!prev_ready) check("freeze", {17'd0, cur}, {17'd0, snap});
      if (o_issue_valid && prev_ready) begin
        if (iss_q.size() == 0) check("extra_issue", 1, 0);
        else begin
          if (iss_q.size() == 2 * n) check("first_issue_cyc", cyc, 1);
          check("row_pass", {26'd0, o_pass, o_row}, {26'd0, iss_q.pop_front()});
          cyc_q.push_back(cyc);
        end
      end
      if (o_dly_valid && prev_ready) begin
        if (dly_q.size() == 0) check("extra_dly", 1, 0);
        else begin
          check("en_inv", {28'd0, o_en_8, o_en_16, o_en_32, o_inverse}, {28'd0, dly_q.pop_front()});
          ic = cyc_q.pop_front();
          if (stall_row < 0) check("latency", cyc - ic, P);
        end
      end
      if (!o_dly_valid) check("en_idle", {o_en_8, o_en_16, o_en_32, o_inverse}, 0);
      if (o_done) begin
        check("done_cyc", cyc, exp_done);
        check("busy_at_done", o_busy, 0);
        done_seen = 1;
      end
      if (stall_row >= 0 && !stalled && o_issue_valid && !o_pass && o_row == stall_row[4:0]) begin
        stalled    = 1;
        stall_left = 3;
      end
      i_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      i_start = mid_start && stalled && stall_left == 1;
      prev_ready = i_ready;
      snap = cur;
    end
    if (!done_seen) check("done_timeout", 0, 1);
    check("issue_left", iss_q.size(), 0);
    check("dly_left", dly_q.size(), 0);
    i_start = 1'b0;
    i_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("done_once", o_done, 0);
      check("idle_after", {o_busy, o_issue_valid}, 0);
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; i_start = 1'b1; i_size = 2'd3; i_inverse = 1'b1; i_ready = 1'b1;
    #2 check("rst_outs_async", {17'd0, all_outs()}, 0);
    repeat (3) @(negedge clk);
    check("rst_outs_held", {17'd0, all_outs()}, 0);
    i_start = 1'b0;
    rst_n   = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("idle_busy_issue", {o_busy, o_issue_valid}, 0);
    end

    run_block(2'd1, 1'b0, -1, 0);
    run_block(2'd3, 1'b1, -1, 0);
    run_block(2'd0, 1'b0, -1, 0);
    run_block(2'd2, 1'b0, 5, 1);

    @(negedge clk);
    i_size = 2'd1; i_inverse = 1'b0; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      found = o_issue_valid && o_pass && o_row == 5'd2;
    end
    check("reach_p1_r2", found, 1);
    #1 rst_n = 1'b0;
    #1 check("rst_mid_outs", {17'd0, all_outs()}, 0);
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", o_done, 0);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_idle", {o_busy, o_done}, 0);
    end
    run_block(2'd1, 1'b0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tq_premuat_sched.md
Name: tq_premuat_sched

Overview:
- Sequencer for the transform datapath's input-permutation ("premuat") stages.
- Takes one start command per transform block (size 4/8/16/32, forward or inverse) and issues row indices for two passes: pass 0 is rows, pass 1 is columns.
- Generates the per-size permutation enables and the inverse select, delayed to line up with the datapath register stages.
- Sits between the TQ top-level control and the 4/8/16/32-point butterfly chain; honours downstream backpressure.

Parameters:
- PIPE_DEPTH, 2, register stages between row issue and the permutation mux inputs. Range 1..4.
- ROW_W, 5, width of the row index (covers 32 rows).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- i_start  in  1  start-of-block pulse; sampled only in IDLE
- i_size  in  2  transform size: 0=4x4, 1=8x8, 2=16x16, 3=32x32; latched at start
- i_inverse  in  1  0=forward, 1=inverse; latched at start
- i_ready  in  1  downstream can accept a row this cycle
- o_busy  out  1  state != IDLE
- o_issue_valid  out  1  a row is issued this cycle
- o_row  out  ROW_W  issued row index
- o_pass  out  1  issued pass: 0=row, 1=column
- o_dly_valid  out  1  delayed valid aligned to the permutation stage
- o_en_8  out  1  enable for the 8-point permutation, aligned
- o_en_16  out  1  enable for the 16-point permutation, aligned
- o_en_32  out  1  enable for the 32-point permutation, aligned
- o_inverse  out  1  inverse select, aligned
- o_done  out  1  one-cycle pulse: block fully drained

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n). The polarity and synchronicity are fixed.
- Reset values: all outputs 0, state IDLE, counters 0, delay line cleared. Reset mid-block abandons the block; no o_done is produced.
- States: IDLE, PASS0, PASS1, DRAIN.
- IDLE:
  - i_start=1 latches size and inverse, clears the row counter, moves to PASS0.
  - i_start in any other state is ignored.
  - i_size and i_inverse changes after the latch are ignored.
- PASS0 / PASS1:
  - o_issue_valid=1; o_row = counter; o_pass = (state==PASS1).
  - Row count N = 4 << size.
  - Counter advances only when i_ready=1. With i_ready=0, row, pass and state all hold.
  - Accepted row N-1 in PASS0 -> PASS1 next cycle, counter back to 0. There are no bubble cycles between passes.
  - Accepted row N-1 in PASS1 -> DRAIN, drain counter cleared.
- DRAIN:
  - o_issue_valid=0.
  - Counts PIPE_DEPTH cycles in which i_ready=1.
  - Then asserts o_done for one cycle and returns to IDLE in that same cycle. o_busy=0 while o_done=1.
  - A new i_start is accepted in the o_done cycle.
- Delay line:
  - PIPE_DEPTH-deep shift of {valid, en_8, en_16, en_32, inverse}.
  - Shifts only when i_ready=1, freezing together with the datapath.
  - Stage input: valid = o_issue_valid; en_8 = (size>=1); en_16 = (size>=2); en_32 = (size==3); inverse = latched inverse.
  - The enables are ANDed with the stage's valid. When delayed valid=0, all enables read 0.
- Latency: row issued in cycle t with i_ready held high appears on o_dly_valid/enables in cycle t+PIPE_DEPTH.
- 4x4: all permutation enables stay 0; rows are still sequenced (4 per pass).
- Timing, with start sampled at edge 0, i_ready constant 1 and PIPE_DEPTH=2:
  - Row 0 of pass 0 is issued in cycle 1.
  - Total issue cycles = 2N.
  - o_done in cycle 2N+PIPE_DEPTH+1.

Decomposition:
- Shared package tq_pkg:
  - size encodings TQ_SIZE_4/8/16/32
  - state encodings for IDLE, PASS0, PASS1, DRAIN
  - function rows_of_size(size) returning 4<<size
- Sub-module tq_align_dly: stall-able PIPE_DEPTH shift register. Parameterised width and depth, shift-enable input, async active-low clear. Reused elsewhere in the TQ pipeline.

Test Plan:
- Reset/idle:
  - Stimulus: assert rst_n=0 with i_start=1.
  - Required: all outputs 0.
  - Stimulus: release rst_n, keep i_start=0 for 10 cycles.
  - Required: o_busy=0; o_issue_valid=0.
- 8x8 forward, i_ready=1, PIPE_DEPTH=2, start at edge 0:
  - Issue: rows 0..7 pass 0 in cycles 1..8; rows 0..7 pass 1 in cycles 9..16.
  - Aligned outputs: o_en_8=1, o_en_16=0, o_inverse=0 in cycles 3..18.
  - Completion: o_done in cycle 19 only.
- 32x32 inverse:
  - Required: 64 issue cycles; o_en_8=o_en_16=o_en_32=1 and o_inverse=1 on every o_dly_valid cycle.
  - Required: o_done at cycle 67.
- 4x4 forward:
  - Required: 8 issue cycles; all enables 0 throughout.
  - Required: o_done at cycle 11.
- Backpressure, 16x16:
  - Stimulus: drop i_ready for 3 cycles while o_row=5 in pass 0.
  - Required: o_row stays 5; delayed outputs freeze; o_done is delayed by exactly 3 cycles (cycle 38 instead of 35).
  - Stimulus: i_start pulsed mid-block.
  - Required: no effect.
- Reset mid-block:
  - Stimulus: rst_n=0 during pass 1 row 2.
  - Required: outputs 0 immediately; no o_done.
  - Stimulus: new start after release.
  - Required: sequences normally from pass 0 row 0.
